// File: rtl/flood_pkg.sv
// Shared types and helpers for the flood-fill engine: FSM states, BFS
// neighbour directions and the {row,col} RAM address packing.
package flood_pkg;

    localparam int unsigned COLOR_W_DEF = 3;
    localparam int unsigned CW_DEF      = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_POP,
        S_NRD,
        S_NCHK,
        S_SCAN,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // Callers cast the result down to 2*cw bits.
    function automatic logic [31:0] pack_addr(input logic [15:0] row,
                                              input logic [15:0] col,
                                              input int unsigned cw);
        return (32'(row) << cw) | 32'(col);
    endfunction

    function automatic dir_t next_dir(input dir_t d);
        dir_t n;
        case (d)
            DIR_UP:   n = DIR_DOWN;
            DIR_DOWN: n = DIR_LEFT;
            DIR_LEFT: n = DIR_RIGHT;
            default:  n = DIR_UP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/flood_board_ram.sv
// Board storage: port A is read/write for loading and filling, port B is a
// read-only display port. Both reads are synchronous with one-cycle latency.
module flood_board_ram #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [DW-1:0] b_rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;

    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
    end

    // Only the read registers are reset so that outputs clear with the engine.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= mem_q[a_addr_i];
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/flood_fill_engine.sv
// Flood-It move engine: recolours the region connected to (0,0) with a
// circular-queue BFS, then scans the board for a win.
module flood_fill_engine
    import flood_pkg::*;
#(
    parameter int unsigned MAX_SIZE = 26,
    parameter int unsigned COLOR_W  = COLOR_W_DEF,
    parameter int unsigned CW       = CW_DEF,
    parameter int unsigned QDEPTH   = MAX_SIZE * MAX_SIZE,
    parameter int unsigned MOVE_W   = 10
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic [CW:0]        SIZE,
    input  logic [3:0]         NUM_COLORS,
    input  logic               NEW_GAME,
    input  logic               LOAD_WE,
    input  logic [CW-1:0]      LOAD_ROW,
    input  logic [CW-1:0]      LOAD_COL,
    input  logic [COLOR_W-1:0] LOAD_COLOR,
    input  logic               CMD_VALID,
    input  logic [COLOR_W-1:0] CMD_COLOR,
    output logic               CMD_READY,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [MOVE_W-1:0]  MOVE_COUNT,
    output logic [2*CW-1:0]    FILLED_COUNT,
    output logic               WIN,
    input  logic [CW-1:0]      RD_ROW,
    input  logic [CW-1:0]      RD_COL,
    output logic [COLOR_W-1:0] RD_COLOR
);

    localparam int unsigned AW  = 2 * CW;
    localparam int unsigned SW  = CW + 1;
    localparam int unsigned QPW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned QCW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [SW-1:0] ONE_S = SW'(1);

    state_t               state_q;
    dir_t                 dir_q;
    logic [SW-1:0]        size_q;
    logic [COLOR_W-1:0]   cur_color_q;
    logic [COLOR_W-1:0]   old_q;
    logic [COLOR_W-1:0]   new_q;
    logic [CW-1:0]        r_q;
    logic [CW-1:0]        c_q;
    logic [AW-1:0]        nbr_q;
    logic [CW-1:0]        scan_r_q;
    logic [CW-1:0]        scan_c_q;
    logic                 scan_vld_q;
    logic                 scan_done_q;
    logic                 match_q;
    logic [QPW-1:0]       head_q;
    logic [QPW-1:0]       tail_q;
    logic [QCW-1:0]       cnt_q;
    logic [AW-1:0]        filled_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 win_q;
    logic [MOVE_W-1:0]    move_q;
    logic [AW-1:0]        filled_cnt_q;
    logic [AW-1:0]        queue_q [QDEPTH];

    logic [CW-1:0]        nbr_r_d;
    logic [CW-1:0]        nbr_c_d;
    logic                 nbr_ok_d;
    logic                 load_ok_d;
    logic                 cmd_ready_d;
    logic                 hit_d;
    logic                 push_en_d;
    logic [AW-1:0]        push_data_d;
    logic [AW-1:0]        head_entry_d;
    logic                 scan_last_d;
    logic                 ram_we_d;
    logic [AW-1:0]        ram_addr_d;
    logic [COLOR_W-1:0]   ram_wdata_d;
    logic [COLOR_W-1:0]   ram_rdata;

    function automatic logic [QPW-1:0] q_next(input logic [QPW-1:0] p);
        return (p == QPW'(QDEPTH - 1)) ? '0 : p + QPW'(1);
    endfunction

    flood_board_ram #(
        .AW (AW),
        .DW (COLOR_W)
    ) u_ram (
        .clk_i     (CLOCK),
        .rst_ni    (RESET_N),
        .a_we_i    (ram_we_d),
        .a_addr_i  (ram_addr_d),
        .a_wdata_i (ram_wdata_d),
        .a_rdata_o (ram_rdata),
        .b_addr_i  (AW'(pack_addr(16'(RD_ROW), 16'(RD_COL), CW))),
        .b_rdata_o (RD_COLOR)
    );

    assign cmd_ready_d  = (state_q == S_IDLE) && !LOAD_WE;
    assign load_ok_d    = (state_q == S_IDLE) && LOAD_WE && !NEW_GAME &&
                          ({1'b0, LOAD_ROW} < size_q) && ({1'b0, LOAD_COL} < size_q);
    assign hit_d        = (ram_rdata == old_q);
    assign head_entry_d = queue_q[head_q];
    assign scan_last_d  = ({1'b0, scan_r_q} == size_q - ONE_S) &&
                          ({1'b0, scan_c_q} == size_q - ONE_S);
    assign push_en_d    = !NEW_GAME &&
                          ((state_q == S_SEED) || ((state_q == S_NCHK) && hit_d));
    assign push_data_d  = (state_q == S_SEED) ? '0 : nbr_q;

    always_comb begin
        nbr_r_d  = r_q;
        nbr_c_d  = c_q;
        nbr_ok_d = 1'b0;
        case (dir_q)
            DIR_UP: begin
                nbr_r_d  = r_q - ONE_C;
                nbr_ok_d = (r_q != '0);
            end
            DIR_DOWN: begin
                nbr_r_d  = r_q + ONE_C;
                nbr_ok_d = ({1'b0, r_q} + ONE_S) < size_q;
            end
            DIR_LEFT: begin
                nbr_c_d  = c_q - ONE_C;
                nbr_ok_d = (c_q != '0);
            end
            DIR_RIGHT: begin
                nbr_c_d  = c_q + ONE_C;
                nbr_ok_d = ({1'b0, c_q} + ONE_S) < size_q;
            end
            default: ;
        endcase
    end

    // Port A is shared by loads, the BFS neighbour read/write and the win scan.
    always_comb begin
        ram_we_d    = 1'b0;
        ram_addr_d  = AW'(pack_addr(16'(scan_r_q), 16'(scan_c_q), CW));
        ram_wdata_d = new_q;
        case (state_q)
            S_IDLE: begin
                if (load_ok_d) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = AW'(pack_addr(16'(LOAD_ROW), 16'(LOAD_COL), CW));
                    ram_wdata_d = LOAD_COLOR;
                end
            end
            S_SEED: begin
                ram_we_d   = 1'b1;
                ram_addr_d = '0;
            end
            S_NRD: begin
                ram_addr_d = AW'(pack_addr(16'(nbr_r_d), 16'(nbr_c_d), CW));
            end
            S_NCHK: begin
                ram_we_d   = hit_d;
                ram_addr_d = nbr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (push_en_d) begin
            queue_q[tail_q] <= push_data_d;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            dir_q        <= DIR_UP;
            size_q       <= SW'(MAX_SIZE);
            cur_color_q  <= '0;
            old_q        <= '0;
            new_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            nbr_q        <= '0;
            scan_r_q     <= '0;
            scan_c_q     <= '0;
            scan_vld_q   <= 1'b0;
            scan_done_q  <= 1'b0;
            match_q      <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            filled_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            win_q        <= 1'b0;
            move_q       <= '0;
            filled_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (NEW_GAME) begin
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                move_q       <= '0;
                filled_cnt_q <= '0;
                win_q        <= 1'b0;
                head_q       <= '0;
                tail_q       <= '0;
                cnt_q        <= '0;
                size_q       <= SIZE;
            end else begin
                if (push_en_d) begin
                    tail_q <= q_next(tail_q);
                    cnt_q  <= cnt_q + QCW'(1);
                end
                case (state_q)
                    S_IDLE: begin
                        if (load_ok_d && (LOAD_ROW == '0) && (LOAD_COL == '0)) begin
                            cur_color_q <= LOAD_COLOR;
                        end
                        if (CMD_VALID && cmd_ready_d) begin
                            if (32'(CMD_COLOR) >= 32'(NUM_COLORS)) begin
                                err_q <= 1'b1;
                            end else if (CMD_COLOR == cur_color_q) begin
                                done_q <= 1'b1;
                            end else begin
                                old_q   <= cur_color_q;
                                new_q   <= CMD_COLOR;
                                busy_q  <= 1'b1;
                                state_q <= S_SEED;
                            end
                        end
                    end
                    S_SEED: begin
                        cur_color_q <= new_q;
                        filled_q    <= AW'(1);
                        state_q     <= S_POP;
                    end
                    S_POP: begin
                        if (cnt_q == '0) begin
                            scan_r_q    <= '0;
                            scan_c_q    <= '0;
                            scan_vld_q  <= 1'b0;
                            scan_done_q <= 1'b0;
                            match_q     <= 1'b1;
                            state_q     <= S_SCAN;
                        end else begin
                            r_q     <= head_entry_d[AW-1:CW];
                            c_q     <= head_entry_d[CW-1:0];
                            head_q  <= q_next(head_q);
                            cnt_q   <= cnt_q - QCW'(1);
                            dir_q   <= DIR_UP;
                            state_q <= S_NRD;
                        end
                    end
                    S_NRD: begin
                        if (nbr_ok_d) begin
                            nbr_q   <= AW'(pack_addr(16'(nbr_r_d), 16'(nbr_c_d), CW));
                            state_q <= S_NCHK;
                        end else if (dir_q == DIR_RIGHT) begin
                            state_q <= S_POP;
                        end else begin
                            dir_q <= next_dir(dir_q);
                        end
                    end
                    S_NCHK: begin
                        if (hit_d) begin
                            filled_q <= filled_q + AW'(1);
                        end
                        if (dir_q == DIR_RIGHT) begin
                            state_q <= S_POP;
                        end else begin
                            dir_q   <= next_dir(dir_q);
                            state_q <= S_NRD;
                        end
                    end
                    S_SCAN: begin
                        // Read data trails the issued address by one cycle.
                        if (scan_vld_q && (ram_rdata != new_q)) begin
                            match_q <= 1'b0;
                        end
                        if (scan_done_q) begin
                            state_q <= S_FINISH;
                        end else begin
                            scan_vld_q <= 1'b1;
                            if (scan_last_d) begin
                                scan_done_q <= 1'b1;
                            end else if ({1'b0, scan_c_q} == size_q - ONE_S) begin
                                scan_c_q <= '0;
                                scan_r_q <= scan_r_q + ONE_C;
                            end else begin
                                scan_c_q <= scan_c_q + ONE_C;
                            end
                        end
                    end
                    S_FINISH: begin
                        win_q        <= match_q;
                        filled_cnt_q <= filled_q;
                        if (move_q != '1) begin
                            move_q <= move_q + MOVE_W'(1);
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign CMD_READY    = cmd_ready_d;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERR          = err_q;
    assign MOVE_COUNT   = move_q;
    assign FILLED_COUNT = filled_cnt_q;
    assign WIN          = win_q;

endmodule

// File: doc/flood_fill_engine.md
Name: flood_fill_engine

Overview:
Parametrised successor to the single-board flood-fill logic. It holds the Flood-It board in an internal dual-port RAM and accepts board loads and colour-move commands through ready/valid handshakes. For each move it recolours the top-left connected region with a circular-FIFO BFS, counts moves and recoloured cells, and runs a win scan. A second RAM port serves the VGA renderer independently of the fill engine.

Parameters:
MAX_SIZE, 26, largest board edge in cells
COLOR_W, 3, bits per cell colour
CW, 5, row/column index width; must satisfy 2^CW >= MAX_SIZE
QDEPTH, MAX_SIZE*MAX_SIZE, BFS queue entries; guarantees the queue never overflows
MOVE_W, 10, move counter width

Ports:
CLOCK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
SIZE  in  CW+1  active board edge, 2..MAX_SIZE; sampled on NEW_GAME
NUM_COLORS  in  4  legal colours are 0..NUM_COLORS-1
NEW_GAME  in  1  pulse that aborts any fill, clears counters and WIN, latches SIZE
LOAD_WE  in  1  board write strobe; honoured only in IDLE
LOAD_ROW, LOAD_COL  in  CW each  load cell address
LOAD_COLOR  in  COLOR_W  load cell value
CMD_VALID  in  1  move request
CMD_COLOR  in  COLOR_W  requested colour
CMD_READY  out  1  equals IDLE and not LOAD_WE
BUSY  out  1  fill or win scan in progress
DONE  out  1  one-cycle pulse when a move completes (including no-op moves)
ERR  out  1  one-cycle pulse when a command is rejected
MOVE_COUNT  out  MOVE_W  moves made; saturates at all-ones
FILLED_COUNT  out  2*CW  number of cells recoloured by the last move
WIN  out  1  whole board is a single colour
RD_ROW, RD_COL  in  CW each  display read address
RD_COLOR  out  COLOR_W  display data, one-cycle latency, always valid

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, state IDLE, queue pointers 0, latched SIZE = MAX_SIZE. RAM contents are undefined after reset; the caller reloads the board.
- RAM address is {row,col} (2*CW bits). Both ports use synchronous read. Port A belongs to load and fill; port B belongs to display only.
- CUR_COLOR register mirrors board[0][0]. It updates on a load to (0,0) and when a fill is seeded.
- Load: in IDLE, LOAD_WE writes the cell only when row and col are both < SIZE; out-of-range writes are dropped. LOAD_WE in any other state is ignored.
- Command acceptance happens on CMD_VALID && CMD_READY.
  - If CMD_COLOR >= NUM_COLORS: ERR pulse on the next cycle; nothing else changes.
  - If CMD_COLOR == CUR_COLOR: DONE pulse on the next cycle; counters unchanged; BUSY stays 0.
  - Otherwise: latch old = CUR_COLOR and new = CMD_COLOR, then go to SEED.
- States:
  - IDLE
  - SEED: write (0,0) = new, push (0,0), FILLED = 1, CUR_COLOR = new.
  - POP: if the queue is empty go to SCAN; otherwise pop into (r,c) and set dir = UP.
  - NRD: if the neighbour in direction dir is in-bounds against SIZE, issue a read; otherwise skip to the next dir.
  - NCHK: if the read data == old, write new to that cell, push it, FILLED++. Then advance dir in order UP, DOWN, LEFT, RIGHT; after RIGHT go to POP.
  - SCAN: read cells 0..SIZE*SIZE-1 row-major, one per cycle, comparing each against new. Clear a mismatch flag on first mismatch and continue to completion.
  - FINISH: WIN = no mismatch, MOVE_COUNT++, FILLED_COUNT = FILLED, DONE pulse, return to IDLE.
- Each cell is recoloured at push time, so it is never pushed twice. The queue is circular with wrap at QDEPTH; full is unreachable.
- Neighbour cost is 2 cycles per in-bounds neighbour and 1 cycle per out-of-bounds neighbour.
- BUSY is high from SEED through FINISH inclusive.
- NEW_GAME has priority over everything in any state: it goes to IDLE at the next edge, clears MOVE_COUNT, FILLED_COUNT and WIN, and flushes the queue. A board left partially filled by an abort is the caller's responsibility.
- LOAD_WE and CMD_VALID in the same IDLE cycle: the load wins and CMD_READY is 0.

Decomposition:
- Package flood_pkg: state enum (IDLE, SEED, POP, NRD, NCHK, SCAN, FINISH), direction enum, COLOR_W and CW defaults, and an address-pack function.
- Sub-module flood_board_ram: 1W/1R + 1R dual-port synchronous RAM with depth 2^(2*CW).
- The BFS queue is an inline register array.

Test Plan:
- SIZE=2, board row0 = {1,2}, row1 = {1,3}, CMD 2 -> (0,0) and (1,0) become 2; FILLED_COUNT=2, MOVE_COUNT=1, WIN=0, DONE pulses once.
- Continue with CMD 3 -> cells (0,0),(1,0),(0,1) become 3; FILLED_COUNT=3, MOVE_COUNT=2, WIN=1.
- CMD equal to CUR_COLOR -> DONE one cycle after acceptance, BUSY never high, MOVE_COUNT unchanged. With NUM_COLORS=6, CMD 6 -> ERR pulse and board unchanged.
- SIZE=26, all cells 0 except (0,0)=1, CMD 0 -> FILLED_COUNT=1, WIN=1. Reload all cells to 0, CMD 5 -> FILLED_COUNT=676, WIN=1, no queue corruption.
- Load with LOAD_ROW=SIZE -> no write, verified via the RD port. Simultaneous LOAD_WE and CMD_VALID -> CMD_READY=0 and the load is applied.
- NEW_GAME mid-fill -> IDLE next cycle with BUSY=0, MOVE_COUNT=0, no DONE. RESET_N low mid-fill -> outputs 0 immediately, asynchronously.
